// File: rtl/wvb_rd_seq_pkg.sv
// Shared FSM encoding and span helper for the wvb read-address sequencer.
package wvb_rd_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_HDR_WAIT = 2'd1,
        S_READ     = 2'd2
    } state_t;

    // Inclusive word count from start to stop around a circular buffer; both must be < depth.
    function automatic int unsigned wvb_mod_span(input int unsigned start,
                                                 input int unsigned stop,
                                                 input int unsigned depth);
        return ((stop + depth - start) % depth) + 1;
    endfunction

endpackage

// File: rtl/wvb_rd_seq_if.sv
// Control/status bundle between the readout FSM (master) and wvb_rd_seq (slave).
// Macro WVB_RD_TRUNC_EN adds cfg_max_len and rd_trunc.
interface wvb_rd_seq_if #(
    parameter int P_ADR_WIDTH = 12
);
    logic [P_ADR_WIDTH-1:0] start_addr;
    logic [P_ADR_WIDTH-1:0] stop_addr;
    logic                   hdr_rdreq;
    logic                   wvb_rdreq;
    logic                   wvb_rddone;
    logic [P_ADR_WIDTH-1:0] wvb_rd_addr;
    logic                   rd_busy;
    logic                   rd_last;
    logic [P_ADR_WIDTH:0]   rd_words_left;
    logic                   addr_err;
`ifdef WVB_RD_TRUNC_EN
    logic [P_ADR_WIDTH:0]   cfg_max_len;
    logic                   rd_trunc;
`endif

    modport master (
`ifdef WVB_RD_TRUNC_EN
        output cfg_max_len,
        input  rd_trunc,
`endif
        output start_addr, stop_addr, hdr_rdreq, wvb_rdreq, wvb_rddone,
        input  wvb_rd_addr, rd_busy, rd_last, rd_words_left, addr_err
    );

    modport slave (
`ifdef WVB_RD_TRUNC_EN
        input  cfg_max_len,
        output rd_trunc,
`endif
        input  start_addr, stop_addr, hdr_rdreq, wvb_rdreq, wvb_rddone,
        output wvb_rd_addr, rd_busy, rd_last, rd_words_left, addr_err
    );

endinterface

// File: rtl/wvb_rd_seq_addr_wrap_inc.sv
// Modulo-P_DEPTH address increment; shared with the write-side controller.
module wvb_addr_wrap_inc #(
    parameter int P_ADR_WIDTH = 12,
    parameter int P_DEPTH     = 4096
) (
    input  logic [P_ADR_WIDTH-1:0] addr,
    output logic [P_ADR_WIDTH-1:0] addr_inc
);
    localparam logic [P_ADR_WIDTH-1:0] LAST_ADR = P_ADR_WIDTH'(P_DEPTH - 1);

    assign addr_inc = (addr == LAST_ADR) ? '0 : addr + P_ADR_WIDTH'(1);

endmodule

// File: rtl/wvb_rd_seq.sv
// Waveform-buffer read address sequencer: circular start..stop walk for the readout FSM.
// Optional macro WVB_RD_TRUNC_EN caps each event at cfg_max_len words.
module wvb_rd_seq
    import wvb_rd_seq_pkg::*;
#(
    parameter int P_ADR_WIDTH = 12,
    parameter int P_DEPTH     = 4096,
    parameter int P_HDR_LAT   = 2
) (
    input logic         clk,
    input logic         rst,
    wvb_rd_seq_if.slave bus
);
    localparam int          W        = P_ADR_WIDTH;
    localparam logic [W:0]   DEPTH_W  = (W+1)'(P_DEPTH);
    localparam logic [W-1:0] LAST_ADR = W'(P_DEPTH - 1);
    localparam logic [2:0]   LAT      = 3'(P_HDR_LAT);
    localparam int unsigned  DEPTH_U  = P_DEPTH;

    state_t       state_q, state_d;
    logic [2:0]   lat_cnt;
    logic [W-1:0] addr_q, stop_q, addr_nxt;
    logic [W:0]   words_q;
    logic         busy_q, err_q;
    logic         do_hdr, do_load, do_done, do_step;
    logic [W-1:0] start_c, stop_c, stop_eff;
    logic [W:0]   len_c, len_eff;
    logic         start_oor, stop_oor;
`ifdef WVB_RD_TRUNC_EN
    logic         trunc_c, trunc_q;
`endif

    wvb_addr_wrap_inc #(.P_ADR_WIDTH(W), .P_DEPTH(P_DEPTH)) u_wrap_inc (
        .addr     (addr_q),
        .addr_inc (addr_nxt)
    );

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: each always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (bus.hdr_rdreq) begin
            state_d = S_HDR_WAIT;
        end else begin
            case (state_q)
                S_HDR_WAIT: if (lat_cnt == LAT) state_d = S_READ;
                S_READ:     if (bus.wvb_rddone) state_d = S_IDLE;
                default:    state_d = state_q;
            endcase
        end
    end

    // Strobes follow the in-cycle priority: header > latency expiry > done > advance.
    always_comb begin
        do_hdr  = bus.hdr_rdreq;
        do_load = !do_hdr && (state_q == S_HDR_WAIT) && (lat_cnt == LAT);
        do_done = !do_hdr && (state_q == S_READ) && bus.wvb_rddone;
        do_step = !do_hdr && (state_q == S_READ) && !bus.wvb_rddone
                  && bus.wvb_rdreq && (addr_q != stop_q);
    end

    // Load-time values: clamp out-of-range addresses, then size (and optionally cap) the event.
    always_comb begin
        start_oor = ({1'b0, bus.start_addr} >= DEPTH_W);
        stop_oor  = ({1'b0, bus.stop_addr} >= DEPTH_W);
        start_c   = start_oor ? LAST_ADR : bus.start_addr;
        stop_c    = stop_oor ? LAST_ADR : bus.stop_addr;
        len_c     = (W+1)'(wvb_mod_span(32'(start_c), 32'(stop_c), DEPTH_U));
`ifdef WVB_RD_TRUNC_EN
        trunc_c   = (bus.cfg_max_len != '0) && (len_c > bus.cfg_max_len);
        stop_eff  = trunc_c ? W'((32'(start_c) + 32'(bus.cfg_max_len) - 32'd1) % DEPTH_U) : stop_c;
        len_eff   = trunc_c ? bus.cfg_max_len : len_c;
`else
        stop_eff  = stop_c;
        len_eff   = len_c;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt <= '0;
            addr_q  <= '1;
            stop_q  <= '0;
            words_q <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef WVB_RD_TRUNC_EN
            trunc_q <= 1'b0;
`endif
        end else begin
            if (do_hdr) begin
                lat_cnt <= 3'd1;
                busy_q  <= 1'b0;
                words_q <= '0;
            end else if (do_load) begin
                addr_q  <= start_c;
                stop_q  <= stop_eff;
                words_q <= len_eff;
                busy_q  <= 1'b1;
                err_q   <= err_q | start_oor | stop_oor;
`ifdef WVB_RD_TRUNC_EN
                trunc_q <= trunc_c;
`endif
            end else if (do_done) begin
                addr_q  <= stop_q;
                busy_q  <= 1'b0;
                words_q <= '0;
            end else if (do_step) begin
                addr_q  <= addr_nxt;
                words_q <= words_q - (W+1)'(1);
            end
            if (!do_hdr && !do_load && state_q == S_HDR_WAIT) lat_cnt <= lat_cnt + 3'd1;
        end
    end

    assign bus.wvb_rd_addr   = addr_q;
    assign bus.rd_busy       = busy_q;
    assign bus.rd_last       = busy_q && (addr_q == stop_q);
    assign bus.rd_words_left = words_q;
    assign bus.addr_err      = err_q;
`ifdef WVB_RD_TRUNC_EN
    assign bus.rd_trunc      = trunc_q;
`endif

endmodule

// File: tb/tb_wvb_rd_seq.sv
// Bench for wvb_rd_seq: instance A (13-bit, depth 4096) and B (12-bit, depth 3000) driven in lockstep.
// Define WVB_RD_TRUNC_EN to also exercise the truncation option.
`timescale 1ns/1ps
module tb_wvb_rd_seq;
    localparam int LAT = 2;
    localparam int W_A = 13;
    localparam int D_A = 4096;
    localparam int W_B = 12;
    localparam int D_B = 3000;

    logic           clk = 1'b0;
    logic           rst;
    logic [W_A-1:0] start_addr, stop_addr;
    logic           hdr_rdreq, wvb_rdreq, wvb_rddone;
`ifdef WVB_RD_TRUNC_EN
    logic [W_A:0]   cfg_max_len;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wvb_rd_seq_if #(.P_ADR_WIDTH(W_A)) if_a ();
    wvb_rd_seq_if #(.P_ADR_WIDTH(W_B)) if_b ();

    assign if_a.start_addr = start_addr;
    assign if_a.stop_addr  = stop_addr;
    assign if_a.hdr_rdreq  = hdr_rdreq;
    assign if_a.wvb_rdreq  = wvb_rdreq;
    assign if_a.wvb_rddone = wvb_rddone;
    assign if_b.start_addr = start_addr[W_B-1:0];
    assign if_b.stop_addr  = stop_addr[W_B-1:0];
    assign if_b.hdr_rdreq  = hdr_rdreq;
    assign if_b.wvb_rdreq  = wvb_rdreq;
    assign if_b.wvb_rddone = wvb_rddone;
`ifdef WVB_RD_TRUNC_EN
    assign if_a.cfg_max_len = cfg_max_len;
    assign if_b.cfg_max_len = cfg_max_len[W_B:0];
`endif

    wvb_rd_seq #(.P_ADR_WIDTH(W_A), .P_DEPTH(D_A), .P_HDR_LAT(LAT)) u_dut_a (
        .clk (clk), .rst (rst), .bus (if_a)
    );
    wvb_rd_seq #(.P_ADR_WIDTH(W_B), .P_DEPTH(D_B), .P_HDR_LAT(LAT)) u_dut_b (
        .clk (clk), .rst (rst), .bus (if_b)
    );

    // Reference model: an event is (start, length); position counts words already stepped past.
    int depth [2] = '{D_A, D_B};
    int mask  [2] = '{(1 << W_A) - 1, (1 << W_B) - 1};
    int m_start [2], m_stop [2], m_len [2], m_pos [2], m_addr [2];
    bit m_busy [2], m_err [2], m_trunc [2];
    int          pre_exp [2];
    logic [31:0] pre_obs [2];

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] words;
        logic        busy;
        logic        last;
        logic        err;
        logic        trunc;
    } obs_t;

    function automatic obs_t sample(input int i);
        obs_t o;
        o.trunc = 1'b0;
        if (i == 0) begin
            o.addr  = 32'(if_a.wvb_rd_addr);
            o.words = 32'(if_a.rd_words_left);
            o.busy  = if_a.rd_busy;
            o.last  = if_a.rd_last;
            o.err   = if_a.addr_err;
`ifdef WVB_RD_TRUNC_EN
            o.trunc = if_a.rd_trunc;
`endif
        end else begin
            o.addr  = 32'(if_b.wvb_rd_addr);
            o.words = 32'(if_b.rd_words_left);
            o.busy  = if_b.rd_busy;
            o.last  = if_b.rd_last;
            o.err   = if_b.addr_err;
`ifdef WVB_RD_TRUNC_EN
            o.trunc = if_b.rd_trunc;
`endif
        end
        return o;
    endfunction

    function automatic int exp_words(input int i);
        return m_busy[i] ? m_len[i] - m_pos[i] : 0;
    endfunction

    function automatic bit exp_last(input int i);
        return m_busy[i] && (m_pos[i] == m_len[i] - 1);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_addr[i] = mask[i]; m_busy[i] = 0; m_err[i] = 0; m_trunc[i] = 0;
            m_pos[i] = 0; m_len[i] = 0; m_start[i] = 0; m_stop[i] = 0;
        end
    endfunction

    function automatic void model_load(input int i, input int s_raw, input int p_raw, input int cfg_raw);
        int s, p, len, cfg;
        s = s_raw & mask[i];
        p = p_raw & mask[i];
        if (s >= depth[i] || p >= depth[i]) m_err[i] = 1;
        if (s >= depth[i]) s = depth[i] - 1;
        if (p >= depth[i]) p = depth[i] - 1;
        len = (p >= s) ? p - s + 1 : (depth[i] - s) + p + 1;
        cfg = cfg_raw & ((mask[i] << 1) | 1);
        m_trunc[i] = 0;
        if (cfg != 0 && len > cfg) begin
            p = (s + cfg - 1) % depth[i];
            len = cfg;
            m_trunc[i] = 1;
        end
        m_start[i] = s; m_stop[i] = p; m_len[i] = len;
        m_pos[i] = 0; m_addr[i] = s; m_busy[i] = 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_load(input int s, input int p, input int cfg, input bit with_rdreq, input bit noise);
        obs_t o;
        start_addr = W_A'(s);
        stop_addr  = W_A'(p);
`ifdef WVB_RD_TRUNC_EN
        cfg_max_len = (W_A+1)'(cfg);
`endif
        hdr_rdreq  = 1'b1;
        wvb_rdreq  = with_rdreq;
        wvb_rddone = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        hdr_rdreq = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            if (k == LAT) begin
                for (int i = 0; i < 2; i++) begin
                    o = sample(i);
                    pre_obs[i] = o.addr;
                    pre_exp[i] = m_addr[i];
                end
            end
            wvb_rdreq  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            wvb_rddone = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        wvb_rdreq  = 1'b0;
        wvb_rddone = 1'b0;
        for (int i = 0; i < 2; i++) model_load(i, s, p, cfg);
    endtask

    task automatic drive_rdreq(input int gap);
        repeat (gap) tick();
        wvb_rdreq = 1'b1;
        tick();
        wvb_rdreq = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (m_busy[i] && m_pos[i] < m_len[i] - 1) begin
                m_pos[i]++;
                m_addr[i] = (m_start[i] + m_pos[i]) % depth[i];
            end
        end
    endtask

    task automatic drive_done();
        wvb_rddone = 1'b1;
        tick();
        wvb_rddone = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (m_busy[i]) begin
                m_addr[i] = m_stop[i];
                m_busy[i] = 0;
            end
        end
    endtask

    task automatic test_reset();
        obs_t o;
        for (int i = 0; i < 2; i++) begin
            o = sample(i);
            checks++;
            if (o.addr !== 32'(mask[i]) || o.words !== 32'd0 || o.busy !== 1'b0 || o.last !== 1'b0
                || o.err !== 1'b0 || o.trunc !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d]: addr=%0d words=%0d busy=%b last=%b err=%b trunc=%b, required addr=%0d others 0",
                         i, o.addr, o.words, o.busy, o.last, o.err, o.trunc, mask[i]);
            end
        end
    endtask

    task automatic test_basic();
        obs_t o;
        int ea, ew;
        drive_load(100, 103, 0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (pre_obs[i] !== 32'(pre_exp[i])) begin
                errors++;
                $display("FAIL basic_latency[%0d]: addr one cycle before load %0d, required %0d", i, pre_obs[i], pre_exp[i]);
            end
            o = sample(i);
            checks++;
            if (o.addr !== 32'd100 || o.words !== 32'd4 || o.busy !== 1'b1 || o.last !== 1'b0) begin
                errors++;
                $display("FAIL basic_load[%0d]: addr=%0d words=%0d busy=%b last=%b, required 100 4 1 0",
                         i, o.addr, o.words, o.busy, o.last);
            end
        end
        for (int n = 1; n <= 5; n++) begin
            drive_rdreq(0);
            ea = (n < 3) ? 100 + n : 103;
            ew = (n < 3) ? 4 - n : 1;
            for (int i = 0; i < 2; i++) begin
                o = sample(i);
                checks++;
                if (o.addr !== 32'(ea) || o.words !== 32'(ew) || o.last !== (n >= 3)) begin
                    errors++;
                    $display("FAIL basic_step%0d[%0d]: addr=%0d words=%0d last=%b, required %0d %0d %b",
                             n, i, o.addr, o.words, o.last, ea, ew, n >= 3);
                end
            end
        end
    endtask

    task automatic test_wrap();
        obs_t o;
        int seq_b [4] = '{2998, 2999, 0, 1};
        int seq_a [4] = '{4094, 4095, 0, 1};
        drive_load(2998, 1, 0, 1'b0, 1'b0);
        for (int n = 0; n < 4; n++) begin
            if (n > 0) drive_rdreq(1);
            o = sample(1);
            checks++;
            if (o.addr !== 32'(seq_b[n]) || o.words !== 32'(4 - n) || o.last !== (n == 3)) begin
                errors++;
                $display("FAIL wrap_b%0d: addr=%0d words=%0d last=%b, required %0d %0d %b",
                         n, o.addr, o.words, o.last, seq_b[n], 4 - n, n == 3);
            end
        end
        drive_load(4094, 1, 0, 1'b0, 1'b0);
        for (int n = 0; n < 4; n++) begin
            if (n > 0) drive_rdreq(0);
            o = sample(0);
            checks++;
            if (o.addr !== 32'(seq_a[n]) || o.words !== 32'(4 - n) || o.last !== (n == 3)) begin
                errors++;
                $display("FAIL wrap_a%0d: addr=%0d words=%0d last=%b, required %0d %0d %b",
                         n, o.addr, o.words, o.last, seq_a[n], 4 - n, n == 3);
            end
        end
    endtask

    task automatic test_abort();
        obs_t o;
        drive_load(10, 50, 0, 1'b0, 1'b0);
        repeat (3) drive_rdreq(0);
        drive_done();
        for (int i = 0; i < 2; i++) begin
            o = sample(i);
            checks++;
            if (o.addr !== 32'd50 || o.busy !== 1'b0 || o.words !== 32'd0 || o.last !== 1'b0) begin
                errors++;
                $display("FAIL abort[%0d]: addr=%0d busy=%b words=%0d last=%b, required 50 0 0 0",
                         i, o.addr, o.busy, o.words, o.last);
            end
        end
        drive_rdreq(0);
        drive_done();
        for (int i = 0; i < 2; i++) begin
            o = sample(i);
            checks++;
            if (o.addr !== 32'd50 || o.busy !== 1'b0 || o.words !== 32'd0) begin
                errors++;
                $display("FAIL idle_ignore[%0d]: addr=%0d busy=%b words=%0d, required 50 0 0", i, o.addr, o.busy, o.words);
            end
        end
    endtask

    task automatic test_hdr_priority();
        obs_t o;
        drive_load(200, 210, 0, 1'b0, 1'b0);
        repeat (2) drive_rdreq(0);
        drive_load(300, 305, 0, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            o = sample(i);
            checks++;
            if (pre_obs[i] !== 32'd202 || o.addr !== 32'd300 || o.words !== 32'd6 || o.busy !== 1'b1) begin
                errors++;
                $display("FAIL hdr_priority[%0d]: pre_addr=%0d addr=%0d words=%0d busy=%b, required 202 300 6 1",
                         i, pre_obs[i], o.addr, o.words, o.busy);
            end
        end
    endtask

    task automatic test_range();
        obs_t o;
        drive_load(5000, 3500, 0, 1'b0, 1'b0);
        o = sample(0);
        checks++;
        if (o.err !== 1'b1 || o.addr !== 32'd4095 || o.words !== 32'd3502) begin
            errors++;
            $display("FAIL range_a: err=%b addr=%0d words=%0d, required 1 4095 3502", o.err, o.addr, o.words);
        end
        o = sample(1);
        checks++;
        if (o.err !== 1'b1 || o.addr !== 32'(m_addr[1]) || o.words !== 32'(exp_words(1))) begin
            errors++;
            $display("FAIL range_b: err=%b addr=%0d words=%0d, required 1 %0d %0d", o.err, o.addr, o.words, m_addr[1], exp_words(1));
        end
        drive_load(1, 2, 0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            o = sample(i);
            checks++;
            if (o.err !== 1'b1 || o.addr !== 32'd1) begin
                errors++;
                $display("FAIL range_sticky[%0d]: err=%b addr=%0d, required 1 1", i, o.err, o.addr);
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t o;
        drive_load(20, 40, 0, 1'b0, 1'b0);
        repeat (2) drive_rdreq(0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            o = sample(i);
            checks++;
            if (o.addr !== 32'(mask[i]) || o.busy !== 1'b0 || o.words !== 32'd0 || o.last !== 1'b0 || o.err !== 1'b0) begin
                errors++;
                $display("FAIL async_reset[%0d]: addr=%0d busy=%b words=%0d last=%b err=%b, required %0d 0 0 0 0",
                         i, o.addr, o.busy, o.words, o.last, o.err, mask[i]);
            end
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

`ifdef WVB_RD_TRUNC_EN
    task automatic test_trunc();
        obs_t o;
        int seq [8] = '{4090, 4091, 4092, 4093, 4094, 4095, 0, 1};
        drive_load(4090, 20, 8, 1'b0, 1'b0);
        o = sample(0);
        checks++;
        if (o.trunc !== 1'b1 || o.words !== 32'd8 || o.addr !== 32'd4090) begin
            errors++;
            $display("FAIL trunc_load: trunc=%b words=%0d addr=%0d, required 1 8 4090", o.trunc, o.words, o.addr);
        end
        for (int n = 1; n < 10; n++) begin
            drive_rdreq(0);
            o = sample(0);
            checks++;
            if (o.addr !== 32'(seq[(n < 8) ? n : 7]) || o.last !== (n >= 7)) begin
                errors++;
                $display("FAIL trunc_step%0d: addr=%0d last=%b, required %0d %b", n, o.addr, o.last, seq[(n < 8) ? n : 7], n >= 7);
            end
        end
        drive_load(4090, 20, 0, 1'b0, 1'b0);
        o = sample(0);
        checks++;
        if (o.trunc !== 1'b0 || o.words !== 32'd27) begin
            errors++;
            $display("FAIL trunc_clear: trunc=%b words=%0d, required 0 27", o.trunc, o.words);
        end
    endtask
`endif

    task automatic test_random();
        obs_t o;
        int s, p, cfg, nsteps;
        for (int ev = 0; ev < 40; ev++) begin
            s = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 8191)) : int'($urandom_range(0, 4095));
            p = ($urandom_range(0, 1) == 0) ? ((s + int'($urandom_range(0, 6))) & 8191) : int'($urandom_range(0, 4095));
            cfg = 0;
`ifdef WVB_RD_TRUNC_EN
            if ($urandom_range(0, 1) == 1) cfg = int'($urandom_range(0, 10));
`endif
            nsteps = int'($urandom_range(1, 12));
            for (int st = 0; st <= nsteps; st++) begin
                if (st == 0) drive_load(s, p, cfg, 1'($urandom_range(0, 1)), 1'b1);
                else if (st == nsteps && ev[0]) drive_done();
                else drive_rdreq(int'($urandom_range(0, 2)));
                for (int i = 0; i < 2; i++) begin
                    o = sample(i);
                    checks++;
                    if (o.addr !== 32'(m_addr[i]) || o.words !== 32'(exp_words(i)) || o.busy !== m_busy[i]
                        || o.last !== exp_last(i) || o.err !== m_err[i] || o.trunc !== m_trunc[i]
                        || (st == 0 && pre_obs[i] !== 32'(pre_exp[i]))) begin
                        errors++;
                        $display("FAIL random[%0d] ev%0d st%0d: addr=%0d words=%0d busy=%b last=%b err=%b trunc=%b, required %0d %0d %b %b %b %b",
                                 i, ev, st, o.addr, o.words, o.busy, o.last, o.err, o.trunc,
                                 m_addr[i], exp_words(i), m_busy[i], exp_last(i), m_err[i], m_trunc[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        start_addr = '0;
        stop_addr  = '0;
        hdr_rdreq  = 1'b0;
        wvb_rdreq  = 1'b0;
        wvb_rddone = 1'b0;
`ifdef WVB_RD_TRUNC_EN
        cfg_max_len = '0;
`endif
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        tick();

        test_reset();
        test_basic();
        test_wrap();
        test_abort();
        test_hdr_priority();
        test_range();
        test_async_reset();
`ifdef WVB_RD_TRUNC_EN
        test_trunc();
`endif
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
